nibble_serial_alu_ctrl: RTL

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing a single 4-bit add/sub nibble unit, least-significant nibble first, chaining carry/borrow between cycles. It sits between a requester issuing wide arithmetic operations and the 4-bit add/sub datapath. It owns operand latching, nibble selection, carry chaining and the start/done handshake. The nibble unit is instantiated inside the block.

---
 rtl/nibble_serial_alu_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/nibble_serial_alu_ctrl.sv
// WIDTH-bit add/subtract sequenced through one 4-bit add/sub unit, LS nibble first.
// Optional signed-overflow output `ovf` is enabled by defining ALU_CTRL_OVF_EN.

module nibble_addsub (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       add_sub,
   input  logic       c_in,
   output logic [3:0] r,
   output logic       c_out
);
   logic [4:0] sum;

   // Bit 4 of the 5-bit difference is the borrow when subtracting.
   always_comb begin
      if (add_sub) sum = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
      else         sum = {1'b0, a} - {1'b0, b} - {4'b0000, c_in};
   end

   assign r     = sum[3:0];
   assign c_out = sum[4];
endmodule

module nibble_serial_alu_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             add_sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero
`ifdef ALU_CTRL_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int N  = WIDTH / 4;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   // Handshake: start is accepted only in IDLE or DONE; busy is high for
   // exactly N cycles, then done pulses for one cycle with result valid.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic             accept, last;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic             add_sub_q;
   logic [WIDTH-1:0] a_q, b_q, shadow;
   logic [3:0]       a_nib, b_nib, r_nib;
   logic             c_nib;

   assign accept = start && (state == IDLE || state == DONE);
   assign last   = (cnt == CW'(N - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = start ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign a_nib = 4'(a_q >> {cnt, 2'b00});
   assign b_nib = 4'(b_q >> {cnt, 2'b00});

   nibble_addsub u_nib (
      .a      (a_nib),
      .b      (b_nib),
      .add_sub(add_sub_q),
      .c_in   (carry),
      .r      (r_nib),
      .c_out  (c_nib)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q       <= '0;
         b_q       <= '0;
         add_sub_q <= 1'b0;
         carry     <= 1'b0;
         cnt       <= '0;
         shadow    <= '0;
         result    <= '0;
         cout      <= 1'b0;
`ifdef ALU_CTRL_OVF_EN
         ovf       <= 1'b0;
`endif
      end else if (accept) begin
         a_q       <= a;
         b_q       <= b;
         add_sub_q <= add_sub;
         carry     <= cin;
         cnt       <= '0;
      end else if (state == RUN) begin
         for (int k = 0; k < N; k++)
            if (cnt == CW'(k)) shadow[k*4 +: 4] <= r_nib;
         carry <= c_nib;
         cnt   <= cnt + 1'b1;
         // Top nibble is still in flight on the final cycle, so splice it in.
         if (last) begin
            result <= {r_nib, shadow[WIDTH-5:0]};
            cout   <= c_nib;
`ifdef ALU_CTRL_OVF_EN
            if (add_sub_q)
               ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (r_nib[3] != a_q[WIDTH-1]);
            else
               ovf <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (r_nib[3] != a_q[WIDTH-1]);
`endif
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);
   assign zero = (result == '0);
endmodule
